// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word requests, tags them with their PC and
// buffers returned instructions for decode. Redirects flush wrong-path work.
module instr_fetch #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [31:20]          Imm_up,
  output logic [11:7]           Imm_down
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         tag_rd_q, tag_rd_d;
  logic [PW-1:0]         tag_wr_q, tag_wr_d;

  logic [DATA_WIDTH-1:0] buf_instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] tag_pc_q    [DEPTH];

  logic          rsp_ok, rsp_keep, req_fire, consume;
  logic [CW:0]   occ;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0) && !redirect_valid;
  assign consume     = instr_valid && !stall;
  assign rsp_ok      = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep    = rsp_ok && (drop_q == '0) && !redirect_valid;

  // A head leaving this cycle frees its slot, which keeps a 1-cycle
  // memory streaming at one word per cycle.
  assign occ = {1'b0, inflight_q} + {1'b0, count_q}
             - {{CW{1'b0}}, consume};

  assign imem_req_valid = !rst && !redirect_valid && (occ < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr    = buf_instr_q[rd_ptr_q];
  assign instr_pc = buf_pc_q[rd_ptr_q];
  assign Imm_up   = instr[31:20];
  assign Imm_down = instr[11:7];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_wr_d   = tag_wr_q + PW'(req_fire);
    tag_rd_d   = tag_rd_q + PW'(rsp_ok);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      drop_d     = inflight_q - CW'(rsp_ok);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
      count_d  = count_q + CW'(rsp_keep) - CW'(consume);
      wr_ptr_d = wr_ptr_q + PW'(rsp_keep);
      rd_ptr_d = rd_ptr_q + PW'(consume);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
        tag_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      if (req_fire) tag_pc_q[tag_wr_q] <= fetch_pc_q;
      if (rsp_keep) begin
        buf_instr_q[wr_ptr_q] <= imem_rsp_data;
        buf_pc_q[wr_ptr_q]    <= tag_pc_q[tag_rd_q];
      end
    end
  end

endmodule
